// File: rtl/subbytes_serial_ced_pkg.sv
// Shared types, widths and GF(2^8)/Hamming helpers for the serial SubBytes CED slice.
package aes_ced_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CHK_W  = 4;
  localparam int unsigned SYN_W  = 4;
  localparam int unsigned NBYTES = 16;

  // Hamming column of data bit j is HCOLS[4j +: 4]; check bit i uses the unit column 1<<i.
  localparam logic [31:0] HCOLS = 32'hCBA9_7653;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    gmul = p;
  endfunction

  // Inverse as x^254 = product of x^(2^k), k=1..7; zero maps to zero.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [CHK_W-1:0] hcheck(input logic [BYTE_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int unsigned j = 0; j < BYTE_W; j++) begin
      if (d[j]) c = c ^ HCOLS[4*j +: 4];
    end
    hcheck = c;
  endfunction

endpackage

// File: rtl/subbytes_serial_ced_accum.sv
// Per-block fault status, sticky alarm and saturating lifetime fault counter.
module ced_fault_accum
  import aes_ced_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [3:0]       idx,
  input  logic [SYN_W-1:0] syn,
  output logic             blk_err,
  output logic [4:0]       blk_err_cnt,
  output logic [3:0]       first_err_idx,
  output logic [SYN_W-1:0] first_syn,
  output logic             alarm,
  output logic [CNT_W-1:0] fault_total
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_err       <= 1'b0;
      blk_err_cnt   <= '0;
      first_err_idx <= '0;
      first_syn     <= '0;
      alarm         <= 1'b0;
      fault_total   <= '0;
    end else if (start) begin
      blk_err       <= 1'b0;
      blk_err_cnt   <= '0;
      first_err_idx <= '0;
      first_syn     <= '0;
    end else if (en && syn != '0) begin
      blk_err     <= 1'b1;
      blk_err_cnt <= blk_err_cnt + 5'd1;
      if (!blk_err) begin
        first_err_idx <= idx;
        first_syn     <= syn;
      end
      alarm <= 1'b1;
      if (fault_total != '1) fault_total <= fault_total + 1'b1;
    end
  end

endmodule

// File: rtl/subbytes_serial_ced_cells.sv
// S-box, Hamming check predictor and Hamming syndrome checker cells.
module SubBytes
  import aes_ced_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);
  assign dout = sbox(din);
endmodule

module SubBytesHammingPredictor
  import aes_ced_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [CHK_W-1:0]  chk
);
  assign chk = hcheck(sbox(din));
endmodule

module SubBytesHammingChecker
  import aes_ced_pkg::*;
(
  input  logic [BYTE_W+CHK_W-1:0] cw,
  output logic [SYN_W-1:0]        syn
);
  assign syn = cw[CHK_W-1:0] ^ hcheck(cw[BYTE_W+CHK_W-1:CHK_W]);
endmodule

// File: rtl/subbytes_serial_ced.sv
// Byte-serial AES SubBytes with Hamming-based concurrent error detection and fault injection.
module subbytes_serial_ced
  import aes_ced_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter bit          ABORT_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic               inj_en,
  input  logic [3:0]         inj_idx,
  input  logic [11:0]        inj_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               blk_err,
  output logic [4:0]         blk_err_cnt,
  output logic [3:0]         first_err_idx,
  output logic [3:0]         first_syn,
  output logic               alarm,
  output logic [CNT_W-1:0]   fault_total
);

  localparam logic [3:0] LAST = 4'(NBYTES - 1);

  state_t                    state, state_nx;
  logic [3:0]                idx;
  logic [NBYTES*BYTE_W-1:0]  data_q, out_q;
  logic                      inj_en_q;
  logic [3:0]                inj_idx_q;
  logic [BYTE_W+CHK_W-1:0]   inj_mask_q;
  logic [BYTE_W-1:0]         sb_in, sb_out;
  logic [CHK_W-1:0]          pred;
  logic [BYTE_W+CHK_W-1:0]   err, cw;
  logic [SYN_W-1:0]          syn;
  logic                      start, byte_en, fault, abort;

  assign sb_in = data_q[{idx, 3'b000} +: BYTE_W];

  SubBytes                 u_sbox (.din(sb_in), .dout(sb_out));
  SubBytesHammingPredictor u_pred (.din(sb_in), .chk(pred));

  assign err = (inj_en_q && inj_idx_q == idx) ? inj_mask_q : '0;
  assign cw  = {sb_out, pred} ^ err;

  SubBytesHammingChecker   u_chk  (.cw(cw), .syn(syn));

  assign start   = (state == IDLE) && in_valid;
  assign byte_en = (state == RUN);
  assign fault   = byte_en && (syn != '0);
  assign abort   = ABORT_ON_ERR && fault;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (idx == LAST || abort) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      data_q     <= '0;
      out_q      <= '0;
      inj_en_q   <= 1'b0;
      inj_idx_q  <= '0;
      inj_mask_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q     <= in_data;
          inj_en_q   <= inj_en;
          inj_idx_q  <= inj_idx;
          inj_mask_q <= inj_mask;
          idx        <= '0;
        end
        RUN: begin
          // Abort wipes the whole block so no partially substituted state leaks out.
          if (abort) out_q <= '0;
          else       out_q[{idx, 3'b000} +: BYTE_W] <= cw[BYTE_W+CHK_W-1:CHK_W];
          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  ced_fault_accum #(.CNT_W(CNT_W)) u_acc (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .en            (byte_en),
    .idx           (idx),
    .syn           (syn),
    .blk_err       (blk_err),
    .blk_err_cnt   (blk_err_cnt),
    .first_err_idx (first_err_idx),
    .first_syn     (first_syn),
    .alarm         (alarm),
    .fault_total   (fault_total)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_q;

endmodule
